// File: rtl/mirror_display_sequencer_if.sv
// Signal bundle between the mirror display sequencer and its environment.
// master drives the driver/sensor inputs, slave is the sequencer itself.
interface mirror_display_sequencer_if;
    logic       Auto_en;
    logic       Next_btn;
    logic [7:0] Miles_remaining;
    logic [1:0] SS;
    logic       Alert;

    modport master (
        output Auto_en,
        output Next_btn,
        output Miles_remaining,
        input  SS,
        input  Alert
    );

    modport slave (
        input  Auto_en,
        input  Next_btn,
        input  Miles_remaining,
        output SS,
        output Alert
    );
endinterface

// File: rtl/mirror_display_sequencer.sv
// Mirror display page sequencer: manual stepping, timed auto rotation and a
// low-fuel alert that forces the Miles_remaining page and then restores the
// page that was showing before it.
module mirror_display_sequencer #(
    parameter int unsigned DWELL_CYCLES = 100,
    parameter int unsigned ALERT_CYCLES = 200,
    parameter logic [7:0]  MILES_LOW    = 8'd25
) (
    input logic                         clk,
    input logic                         reset,
    mirror_display_sequencer_if.slave   dsp
);

    localparam int unsigned CNT_MAX = (DWELL_CYCLES > ALERT_CYCLES) ? DWELL_CYCLES : ALERT_CYCLES;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] ALERT_LAST = CW'(ALERT_CYCLES - 1);
    localparam logic [1:0]    PAGE_MILES = 2'd3;

    typedef enum logic [1:0] {
        ST_MANUAL,
        ST_AUTO,
        ST_ALERT
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     ss_q, ss_d;
    logic           alert_q, alert_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     saved_q, saved_d;
    logic           armed_q, armed_d;
    logic           btn_q;
    logic           step;
    logic           low;

    // State and output registers; btn_q resets high so a held button is not a step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_MANUAL;
            ss_q    <= '0;
            alert_q <= 1'b0;
            cnt_q   <= '0;
            saved_q <= '0;
            armed_q <= 1'b1;
            btn_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            ss_q    <= ss_d;
            alert_q <= alert_d;
            cnt_q   <= cnt_d;
            saved_q <= saved_d;
            armed_q <= armed_d;
            btn_q   <= dsp.Next_btn;
        end
    end

    // Next-state logic: alert entry preempts every other event in MANUAL/AUTO.
    always_comb begin
        step    = dsp.Next_btn & ~btn_q;
        low     = dsp.Miles_remaining < MILES_LOW;
        state_d = state_q;
        ss_d    = ss_q;
        alert_d = alert_q;
        cnt_d   = cnt_q;
        saved_d = saved_q;
        armed_d = low ? armed_q : 1'b1;

        unique case (state_q)
            ST_MANUAL, ST_AUTO: begin
                if (armed_q && low) begin
                    saved_d = ss_q;
                    ss_d    = PAGE_MILES;
                    alert_d = 1'b1;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                    state_d = ST_ALERT;
                end else if (state_q == ST_MANUAL) begin
                    cnt_d = '0;
                    if (step) ss_d = ss_q + 2'd1;
                    if (dsp.Auto_en) state_d = ST_AUTO;
                end else if (!dsp.Auto_en) begin
                    // Leaving auto drops a pending dwell expiry but still honours a step.
                    cnt_d   = '0;
                    state_d = ST_MANUAL;
                    if (step) ss_d = ss_q + 2'd1;
                end else if (step || cnt_q == DWELL_LAST) begin
                    ss_d  = ss_q + 2'd1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ALERT: begin
                if (step || cnt_q == ALERT_LAST) begin
                    ss_d    = saved_q;
                    alert_d = 1'b0;
                    cnt_d   = '0;
                    state_d = dsp.Auto_en ? ST_AUTO : ST_MANUAL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_MANUAL;
                cnt_d   = '0;
                alert_d = 1'b0;
            end
        endcase
    end

    assign dsp.SS    = ss_q;
    assign dsp.Alert = alert_q;

endmodule
